wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  MEM/WB pipeline register and write-back stage of the 5-stage MIPS pipeline; the producer side of the GRF write port.
//  Latches retiring instructions from MEM, aligns and extends load data, selects the result (ALU / load / PC+8) and drives GRF WE/WA/WD.
//  Exports the true instruction PC for the write trace, so no PC4 arithmetic happens in the GRF.
//  Also drives the WB forwarding source and a retired-instruction counter.
// PARAMETERS
//  CNT_W     32   width of retired_cnt
// PORTS
//  Clk           in   1   clock, rising edge
//  reset         in   1   synchronous, active-high
//  stall_i       in   1   hold MEM/WB register contents
//  flush_i       in   1   invalidate MEM/WB register at next edge
//  m_valid       in   1   MEM stage holds a real instruction
//  m_pc          in   32  PC of the MEM-stage instruction (not PC+4)
//  m_we          in   1   instruction writes a GPR
//  m_rd          in   5   destination register
//  m_wsel        in   2   0=ALU, 1=MEM load, 2=PC+8 (jal/jalr), 3=reserved (selects ALU)
//  m_ld_type     in   3   0=LW, 1=LB, 2=LBU, 3=LH, 4=LHU; others behave as LW
//  m_alu         in   32  ALU result
//  m_mem_rdata   in   32  raw DM word
//  m_addr_lo     in   2   byte address bits [1:0] of the load
//  grf_we        out  1   GRF write enable
//  grf_wa        out  5   GRF write address
//  grf_wd        out  32  GRF write data
//  w_pc          out  32  PC of the instruction currently writing (trace)
//  fwd_valid     out  1   WB holds a pending nonzero-rd result
//  fwd_rd        out  5   forwarding destination
//  fwd_data      out  32  forwarding data (equals grf_wd)
//  retired_cnt   out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  - Registers: w_valid, w_pc, w_we, w_rd, w_wsel, w_ld_type, w_alu, w_rdata, w_addr_lo, w_done, retired_cnt.
//  - reset: all registers 0. Outputs after reset: grf_we=0, grf_wa=0, grf_wd=0, w_pc=0, fwd_valid=0, fwd_rd=0, fwd_data=0, retired_cnt=0.
//  - Edge priority: reset > flush_i > stall_i > load. flush: w_valid<=0, w_done<=0, other fields don't-care.
//    stall: all fields held. load: capture m_* fields, w_valid<=m_valid, w_done<=0.
//  - w_done is set at the edge that ends a cycle in which (w_valid && stall_i) held; it is cleared on any load or flush.
//    Each instruction therefore writes the GRF and counts exactly once, even when held in WB for several cycles.
//  - grf_we = w_valid & w_we & (w_rd!=0) & ~w_done (combinational from registers); latency 1 cycle from MEM.
//  - grf_wa = w_rd; grf_wd = result; w_pc = w_pc register.
//  - Result: ALU -> w_alu; PC+8 -> w_pc+32'd8, wrapping mod 2^32; MEM -> extended load.
//  - Load extension: byte = w_rdata[8*a+7 -: 8] with a=w_addr_lo; LB sign-extends, LBU zero-extends.
//    Halfword = w_addr_lo[1] ? w_rdata[31:16] : w_rdata[15:0]; w_addr_lo[0] ignored; LH sign-extends, LHU zero-extends.
//    LW ignores w_addr_lo.
//  - fwd_valid = w_valid & w_we & (w_rd!=0), not gated by w_done, so forwarding stays correct while stalled.
//    fwd_rd=w_rd, fwd_data=result.
//  - rd==0: no GRF write, no forwarding; the instruction still counts as retired.
//  - retired_cnt increments by 1 at each edge where w_valid & ~w_done & ~reset. It wraps at 2^CNT_W.
//    Flush in the same cycle still counts the instruction currently in WB.
//  - Simultaneous stall_i and flush_i: flush wins. Reset mid-stall clears w_done and the counter.
// STRUCTURE
//  - mips_pkg: WSEL_ALU/WSEL_MEM/WSEL_PC8 and LD_LW/LD_LB/LD_LBU/LD_LH/LD_LHU localparams, shared with the decoder.
//  - One combinational sub-module load_ext (in: rdata, addr_lo, ld_type; out: 32-bit value).
//    Everything else stays in wb_stage.
// TESTING
//  - ALU write: m_valid=1, m_we=1, rd=5, wsel=ALU, alu=0x1234 -> next cycle grf_we=1, wa=5, wd=0x1234; retired_cnt=1 after following edge.
//  - jal: m_pc=0x3000, wsel=PC8, rd=31 -> wd=0x3008, w_pc=0x3000; m_pc=0xFFFFFFFC -> wd=0x00000004.
//  - Loads with rdata=0x80FF7F01: LB a=3 -> 0xFFFFFF80; LBU a=1 -> 0x0000007F; LH a=2 -> 0xFFFF80FF; LHU a=0 -> 0x00007F01; LW a=2 -> 0x80FF7F01.
//  - rd=0, we=1 -> grf_we=0, fwd_valid=0, retired_cnt still increments.
//  - Instruction held by stall_i for 3 cycles: grf_we=1 only in first cycle; fwd_valid=1 all 3 cycles; counter +1 total.
//  - Flush and stall asserted together: next cycle w_valid=0, grf_we=0; reset mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline encodings: write-back result select and load types,
// plus the layout of the MEM/WB pipeline register.
package mips_pkg;

    localparam logic [1:0] WSEL_ALU = 2'd0;
    localparam logic [1:0] WSEL_MEM = 2'd1;
    localparam logic [1:0] WSEL_PC8 = 2'd2;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    // Fields carried from MEM into WB for one retiring instruction.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        we;
        logic [4:0]  rd;
        logic [1:0]  wsel;
        logic [2:0]  ld_type;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [1:0]  addr_lo;
    } mw_t;

endpackage

// File: rtl/load_ext.sv
// Load data alignment and extension: picks the addressed byte/halfword out of
// the raw DM word and sign- or zero-extends it to 32 bits.
module load_ext
    import mips_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  ld_type_i,
    output logic [31:0] value_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select by low address bits; halfword ignores addr bit 0.
    always_comb begin
        byte_v = rdata_i[8*addr_lo_i +: 8];
        half_v = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extend according to load type; unknown encodings behave as LW.
    always_comb begin
        case (ld_type_i)
            LD_LB:   value_o = {{24{byte_v[7]}}, byte_v};
            LD_LBU:  value_o = {24'd0, byte_v};
            LD_LH:   value_o = {{16{half_v[15]}}, half_v};
            LD_LHU:  value_o = {16'd0, half_v};
            default: value_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back stage. Drives the GRF write port,
// the WB forwarding source, the trace PC and a retired-instruction counter.
// w_done marks an instruction that already wrote/counted while held by a
// stall, so a multi-cycle hold retires it exactly once.
module wb_stage
    import mips_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             m_valid,
    input  logic [31:0]      m_pc,
    input  logic             m_we,
    input  logic [4:0]       m_rd,
    input  logic [1:0]       m_wsel,
    input  logic [2:0]       m_ld_type,
    input  logic [31:0]      m_alu,
    input  logic [31:0]      m_mem_rdata,
    input  logic [1:0]       m_addr_lo,
    output logic             grf_we,
    output logic [4:0]       grf_wa,
    output logic [31:0]      grf_wd,
    output logic [31:0]      w_pc,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [31:0]      fwd_data,
    output logic [CNT_W-1:0] retired_cnt
);

    mw_t              mw_q, mw_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      ld_val;
    logic [31:0]      result;
    logic             writes_reg;

    load_ext u_load_ext (
        .rdata_i   (mw_q.rdata),
        .addr_lo_i (mw_q.addr_lo),
        .ld_type_i (mw_q.ld_type),
        .value_o   (ld_val)
    );

    // Next state: flush beats stall beats load; the counter sees the
    // instruction in WB regardless of what happens to the register.
    always_comb begin
        mw_d   = mw_q;
        done_d = done_q;
        cnt_d  = cnt_q;
        if (mw_q.valid && !done_q)
            cnt_d = cnt_q + CNT_W'(1);
        if (flush_i) begin
            mw_d.valid = 1'b0;
            done_d     = 1'b0;
        end else if (stall_i) begin
            done_d = done_q | mw_q.valid;
        end else begin
            mw_d.valid   = m_valid;
            mw_d.pc      = m_pc;
            mw_d.we      = m_we;
            mw_d.rd      = m_rd;
            mw_d.wsel    = m_wsel;
            mw_d.ld_type = m_ld_type;
            mw_d.alu     = m_alu;
            mw_d.rdata   = m_mem_rdata;
            mw_d.addr_lo = m_addr_lo;
            done_d       = 1'b0;
        end
    end

    // MEM/WB register, done flag and counter with synchronous reset.
    always_ff @(posedge Clk) begin
        if (reset) begin
            mw_q   <= '0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            mw_q   <= mw_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
        end
    end

    // Result select; the reserved encoding falls back to the ALU value.
    always_comb begin
        case (mw_q.wsel)
            WSEL_MEM: result = ld_val;
            WSEL_PC8: result = mw_q.pc + 32'd8;
            default:  result = mw_q.alu;
        endcase
    end

    // GRF port writes once; forwarding stays live for the whole hold.
    always_comb begin
        writes_reg  = mw_q.valid & mw_q.we & (mw_q.rd != 5'd0);
        grf_we      = writes_reg & ~done_q;
        grf_wa      = mw_q.rd;
        grf_wd      = result;
        w_pc        = mw_q.pc;
        fwd_valid   = writes_reg;
        fwd_rd      = mw_q.rd;
        fwd_data    = result;
        retired_cnt = cnt_q;
    end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: the driver pushes the hand-computed outputs
// expected one edge after each input vector; a monitor pops and compares them
// on the falling edge of the cycle they are due.
module tb_wb_stage;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_i = 1'b0, flush_i = 1'b0;
    logic        m_valid = 1'b0, m_we = 1'b0;
    logic [31:0] m_pc = '0, m_alu = '0, m_mem_rdata = '0;
    logic [4:0]  m_rd = '0;
    logic [1:0]  m_wsel = '0, m_addr_lo = '0;
    logic [2:0]  m_ld_type = '0;
    logic        grf_we, fwd_valid;
    logic [4:0]  grf_wa, fwd_rd;
    logic [31:0] grf_wd, w_pc, fwd_data, retired_cnt;

    wb_stage #(.CNT_W(32)) dut (
        .Clk(Clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
        .m_valid(m_valid), .m_pc(m_pc), .m_we(m_we), .m_rd(m_rd),
        .m_wsel(m_wsel), .m_ld_type(m_ld_type), .m_alu(m_alu),
        .m_mem_rdata(m_mem_rdata), .m_addr_lo(m_addr_lo),
        .grf_we(grf_we), .grf_wa(grf_wa), .grf_wd(grf_wd), .w_pc(w_pc),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .retired_cnt(retired_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int          due;
        bit          full;   // 0: flushed entry, data fields are don't-care
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        fv;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got 0x%08h want 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compare the entry due in this cycle.
    always @(negedge Clk) begin
        if (q.size() > 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("grf_we", {31'd0, grf_we}, {31'd0, e.we});
            chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, e.fv});
            chk("retired_cnt", retired_cnt, e.cnt);
            if (e.full) begin
                chk("grf_wa", {27'd0, grf_wa}, {27'd0, e.wa});
                chk("fwd_rd", {27'd0, fwd_rd}, {27'd0, e.wa});
                chk("grf_wd", grf_wd, e.wd);
                chk("fwd_data", fwd_data, e.wd);
                chk("w_pc", w_pc, e.pc);
            end
        end
    end

    // Drive one vector and queue the outputs expected after the next edge.
    task automatic drive(
        input logic rst, input logic stl, input logic fl,
        input logic v, input logic [31:0] pc, input logic we, input logic [4:0] rd,
        input logic [1:0] ws, input logic [2:0] lt, input logic [31:0] alu,
        input logic [31:0] rdata, input logic [1:0] alo,
        input bit full, input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
        input logic [31:0] e_pc, input logic e_fv, input logic [31:0] e_cnt);
        exp_t e;
        @(posedge Clk);
        #1;
        reset = rst; stall_i = stl; flush_i = fl;
        m_valid = v; m_pc = pc; m_we = we; m_rd = rd; m_wsel = ws;
        m_ld_type = lt; m_alu = alu; m_mem_rdata = rdata; m_addr_lo = alo;
        e.due = cyc + 1; e.full = full; e.we = e_we; e.wa = e_wa; e.wd = e_wd;
        e.pc = e_pc; e.fv = e_fv; e.cnt = e_cnt;
        q.push_back(e);
    endtask

    localparam logic [31:0] RD = 32'h80FF7F01;

    initial begin
        //    rst stl fl v pc            we rd  ws lt alu           rdata alo | full we wa  wd            pc            fv cnt
        drive(1, 0, 0, 1, 32'h0000_0100, 1, 5,  0, 0, 32'h0000_1234, RD, 0,  1, 0, 0,  32'h0,         32'h0,         0, 0);
        drive(0, 0, 0, 1, 32'h0000_0100, 1, 5,  0, 0, 32'h0000_1234, RD, 0,  1, 1, 5,  32'h0000_1234, 32'h0000_0100, 1, 0);
        drive(0, 0, 0, 1, 32'h0000_3000, 1, 31, 2, 0, 32'h0000_0000, RD, 0,  1, 1, 31, 32'h0000_3008, 32'h0000_3000, 1, 1);
        drive(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 31, 2, 0, 32'h0000_0000, RD, 0,  1, 1, 31, 32'h0000_0004, 32'hFFFF_FFFC, 1, 2);
        drive(0, 0, 0, 1, 32'h0000_0200, 1, 1,  1, 1, 32'h0000_0000, RD, 3,  1, 1, 1,  32'hFFFF_FF80, 32'h0000_0200, 1, 3);
        drive(0, 0, 0, 1, 32'h0000_0204, 1, 2,  1, 2, 32'h0000_0000, RD, 1,  1, 1, 2,  32'h0000_007F, 32'h0000_0204, 1, 4);
        drive(0, 0, 0, 1, 32'h0000_0208, 1, 3,  1, 3, 32'h0000_0000, RD, 2,  1, 1, 3,  32'hFFFF_80FF, 32'h0000_0208, 1, 5);
        drive(0, 0, 0, 1, 32'h0000_020C, 1, 4,  1, 4, 32'h0000_0000, RD, 0,  1, 1, 4,  32'h0000_7F01, 32'h0000_020C, 1, 6);
        drive(0, 0, 0, 1, 32'h0000_0210, 1, 6,  1, 0, 32'h0000_0000, RD, 2,  1, 1, 6,  32'h80FF_7F01, 32'h0000_0210, 1, 7);
        // rd=0: no write, no forwarding, still retires
        drive(0, 0, 0, 1, 32'h0000_0300, 1, 0,  0, 0, 32'h0000_0055, RD, 0,  1, 0, 0,  32'h0000_0055, 32'h0000_0300, 0, 8);
        // three-cycle hold: write in first cycle only, one count total
        drive(0, 0, 0, 1, 32'h0000_0400, 1, 7,  0, 0, 32'h0000_ABCD, RD, 0,  1, 1, 7,  32'h0000_ABCD, 32'h0000_0400, 1, 9);
        drive(0, 1, 0, 1, 32'h0000_0999, 1, 9,  0, 0, 32'h0000_DEAD, RD, 0,  1, 0, 7,  32'h0000_ABCD, 32'h0000_0400, 1, 10);
        drive(0, 1, 0, 1, 32'h0000_0999, 1, 9,  0, 0, 32'h0000_DEAD, RD, 0,  1, 0, 7,  32'h0000_ABCD, 32'h0000_0400, 1, 10);
        drive(0, 0, 0, 1, 32'h0000_0500, 1, 8,  0, 0, 32'h0000_8888, RD, 0,  1, 1, 8,  32'h0000_8888, 32'h0000_0500, 1, 10);
        // stall + flush together: flush wins, instruction in WB still counts
        drive(0, 1, 1, 1, 32'h0000_0999, 1, 9,  0, 0, 32'h0000_DEAD, RD, 0,  0, 0, 0,  32'h0,         32'h0,         0, 11);
        drive(0, 0, 0, 0, 32'h0000_0000, 0, 0,  0, 0, 32'h0000_0000, RD, 0,  1, 0, 0,  32'h0,         32'h0,         0, 11);
        // reset in the middle of a stall
        drive(0, 0, 0, 1, 32'h0000_0600, 1, 10, 0, 0, 32'h0000_0001, RD, 0,  1, 1, 10, 32'h0000_0001, 32'h0000_0600, 1, 11);
        drive(0, 1, 0, 0, 32'h0000_0000, 0, 0,  0, 0, 32'h0000_0000, RD, 0,  1, 0, 10, 32'h0000_0001, 32'h0000_0600, 1, 12);
        drive(1, 1, 0, 1, 32'h0000_0700, 1, 11, 0, 0, 32'h0000_0002, RD, 0,  1, 0, 0,  32'h0,         32'h0,         0, 0);
        drive(0, 0, 0, 0, 32'h0000_0000, 0, 0,  0, 0, 32'h0000_0000, RD, 0,  1, 0, 0,  32'h0,         32'h0,         0, 0);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge Clk);
        @(negedge Clk);
        #1;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expected entries never checked", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
